mdu_iter: RTL

- Iterative multiply/divide unit. Consumes the two register-file read operands (R1/R2) and a destination address.
- Runs a fixed-latency shift-add multiply or restoring divide.
- Drives the register-file write port (Din/WAdr/WE) with the result for one cycle.
- Sits between the register file read side and its write port, parallel to the ALU writeback path.

---
 rtl/mdu_pkg.sv | 13 +
 rtl/mdu_signfix.sv | 25 ++
 rtl/mdu_iter.sv | 99 +++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and default width shared by the multiply/divide unit
package mdu_pkg;
  localparam int MDU_XLEN = 32;
  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
endpackage

// File: rtl/mdu_signfix.sv
// mdu_signfix: turns the magnitude product or {remainder, quotient} into the final signed result
module mdu_signfix import mdu_pkg::*; #(
  parameter int XLEN = MDU_XLEN
) (
  input  logic [2*XLEN-1:0] mag_i,
  input  logic [2:0]        op_i,
  input  logic              sign_a_i,
  input  logic              sign_b_i,
  input  logic              div_zero_i,
  output logic [XLEN-1:0]   res_o
);
  logic              neg;
  logic [2*XLEN-1:0] p;
  logic [XLEN-1:0]   q, r;
  always_comb begin
    neg = sign_a_i ^ sign_b_i;
    p = neg ? -mag_i : mag_i;
    q = mag_i[XLEN-1:0];
    r = mag_i[2*XLEN-1:XLEN];
    res_o = (op_i == MDU_MUL) ? q :
            !op_i[2] ? p[2*XLEN-1:XLEN] :
            !op_i[1] ? (div_zero_i ? '1 : (neg ? -q : q)) :
            (sign_a_i ? -r : r);
  end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative shift-add multiply / restoring divide feeding the register-file write port
module mdu_iter import mdu_pkg::*; #(
  parameter int XLEN = MDU_XLEN,
  parameter int AW   = 5,
  parameter int CW   = 6
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Start,
  input  logic            Flush,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [AW-1:0]   DstAdr,
  output logic            Busy,
  output logic            Done,
  output logic            WE,
  output logic [AW-1:0]   WAdr,
  output logic [XLEN-1:0] Din
);
  state_e            st_q;
  logic [2:0]        op_q;
  logic [AW-1:0]     dst_q, wadr_q;
  logic              sa_q, sb_q, dz_q, fix_q, done_q, we_q;
  logic              sa_d, sb_d;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, din_q, res;
  logic [XLEN:0]     sum, r1, diff;
  always_comb begin
    sa_d = A[XLEN-1] & (Op == MDU_MULH || Op == MDU_MULHSU || Op == MDU_DIV || Op == MDU_REM);
    sb_d = B[XLEN-1] & (Op == MDU_MULH || Op == MDU_DIV || Op == MDU_REM);
    sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    r1   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff = r1 - {1'b0, b_q};
    // acc holds {high product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    acc_d = op_q[2] ? (diff[XLEN] ? {r1[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                    : (acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]});
  end
  mdu_signfix #(.XLEN(XLEN)) u_signfix (
    .mag_i(acc_q), .op_i(op_q), .sign_a_i(sa_q), .sign_b_i(sb_q),
    .div_zero_i(dz_q), .res_o(res)
  );
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st_q <= S_IDLE;
      op_q <= '0;
      dst_q <= '0;
      wadr_q <= '0;
      din_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      dz_q <= 1'b0;
      fix_q <= 1'b0;
      done_q <= 1'b0;
      we_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      b_q <= '0;
    end else begin
      done_q <= 1'b0;
      we_q <= 1'b0;
      if (Flush) st_q <= S_IDLE;
      else if (st_q == S_IDLE) begin
        if (Start) begin
          op_q <= Op;
          dst_q <= DstAdr;
          sa_q <= sa_d;
          sb_q <= sb_d;
          dz_q <= (B == '0);
          acc_q <= {{XLEN{1'b0}}, sa_d ? -A : A};
          b_q <= sb_d ? -B : B;
          cnt_q <= CW'(XLEN - 1);
          fix_q <= 1'b0;
          st_q <= S_CALC;
        end
      end else if (st_q == S_CALC) begin
        // after the last iteration one extra cycle registers the sign-fixed result
        if (fix_q) begin
          din_q <= res;
          wadr_q <= dst_q;
          done_q <= 1'b1;
          we_q <= (dst_q != '0);
          st_q <= S_DONE;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          fix_q <= (cnt_q == '0);
        end
      end else st_q <= S_IDLE;
    end
  end
  assign Busy = (st_q != S_IDLE);
  assign Done = done_q;
  assign WE   = we_q;
  assign WAdr = wadr_q;
  assign Din  = din_q;
endmodule
